// File: rtl/vec_unpack_reader.sv
// vec_unpack_reader
// Read side of a layer's packed output RAM. Element n sits in RAM word n/VEC,
// lane n%VEC, at bits [lane*DATA_WIDTH +: DATA_WIDTH]. A start request fetches
// every word once, unpacks it and streams the scalars in element order on a
// valid/ready port at one element per cycle. A one-word prefetch buffer hides
// the RAM latency at word boundaries.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   one-cycle run request, honoured only when idle
//   busy     out  high from the cycle after start until the final transfer
//   done     out  one-cycle pulse after the final transfer
//   rd_en    out  RAM read strobe
//   rd_addr  out  RAM word address
//   rd_q     in   RAM read data, valid one cycle after rd_en
//   m_valid  out  scalar valid
//   m_ready  in   downstream ready (transfer = m_valid & m_ready)
//   m_data   out  scalar element
//   m_index  out  element index of m_data
//   m_last   out  high with the final element

module vec_unpack_reader #(
  parameter int OUTPUT_DEPTH     = 512,
  parameter int DATA_WIDTH       = 16,
  parameter int VEC              = 16,
  parameter int OUTPUT_VEC_DEPTH = (OUTPUT_DEPTH + VEC - 1) / VEC,
  parameter int ADDR_WIDTH       = (OUTPUT_VEC_DEPTH > 1) ? $clog2(OUTPUT_VEC_DEPTH) : 1,
  parameter int IDX_WIDTH        = (OUTPUT_DEPTH > 1) ? $clog2(OUTPUT_DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [ADDR_WIDTH-1:0]     rd_addr,
  input  logic [VEC*DATA_WIDTH-1:0] rd_q,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic [IDX_WIDTH-1:0]      m_index,
  output logic                      m_last
);

  localparam int LANE_WIDTH = (VEC > 1) ? $clog2(VEC) : 1;
  localparam int WORD_WIDTH = VEC * DATA_WIDTH;

  localparam logic [LANE_WIDTH-1:0] FULL_LANE = LANE_WIDTH'(VEC - 1);
  localparam logic [LANE_WIDTH-1:0] TAIL_LANE = LANE_WIDTH'((OUTPUT_DEPTH - 1) % VEC);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(OUTPUT_VEC_DEPTH - 1);
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(OUTPUT_DEPTH - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH0 = 3'd1;
  localparam logic [2:0] ST_LOAD0  = 3'd2;
  localparam logic [2:0] ST_STREAM = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  logic [2:0]            state_r;
  logic [ADDR_WIDTH-1:0] word_r;      // word currently being unpacked
  logic [LANE_WIDTH-1:0] lane_r;      // lane of the element held in m_data
  logic [WORD_WIDTH-1:0] cur_word_r;
  logic [WORD_WIDTH-1:0] nxt_word_r;
  logic                  nxt_vld_r;
  logic                  pend_r;      // a read was issued last cycle, rd_q is live now

  logic [LANE_WIDTH-1:0] final_lane_s;
  logic [LANE_WIDTH-1:0] lane_inc_s;
  logic [IDX_WIDTH-1:0]  idx_inc_s;
  logic [31:0]           word_ext_s;
  logic                  xfer_s;
  logic                  need_word_s;
  logic                  have_word_s;
  logic                  switch_s;
  logic                  prefetch_s;
  logic [WORD_WIDTH-1:0] src_word_s;

  assign lane_inc_s = lane_r + LANE_WIDTH'(1);
  assign idx_inc_s  = m_index + IDX_WIDTH'(1);
  assign word_ext_s = 32'(word_r);
  assign xfer_s     = (state_r == ST_STREAM) && m_valid && m_ready;

  // The last word may be only partly populated, so its final lane is shorter.
  always_comb begin
    final_lane_s = FULL_LANE;
    if (word_r == LAST_WORD) begin
      final_lane_s = TAIL_LANE;
    end else begin
      final_lane_s = FULL_LANE;
    end
  end

  // Word switch: the final lane of a word was just taken (or an earlier switch
  // stalled for lack of data). The freshly returning RAM data is forwarded
  // directly when the prefetch buffer has not caught it yet.
  always_comb begin
    need_word_s = 1'b0;
    have_word_s = nxt_vld_r | pend_r;
    src_word_s  = rd_q;
    if (nxt_vld_r) begin
      src_word_s = nxt_word_r;
    end else begin
      src_word_s = rd_q;
    end
    if ((state_r == ST_STREAM) && !m_last) begin
      need_word_s = (xfer_s && (lane_r == final_lane_s)) || !m_valid;
    end else begin
      need_word_s = 1'b0;
    end
    switch_s   = need_word_s && have_word_s;
    prefetch_s = switch_s && ((word_ext_s + 32'd2) < 32'(OUTPUT_VEC_DEPTH));
  end

  // RAM read port: word 0 in FETCH0, word 1 in LOAD0, then word+2 on each word switch.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    case (state_r)
      ST_FETCH0: begin
        rd_en   = 1'b1;
        rd_addr = '0;
      end
      ST_LOAD0: begin
        if (OUTPUT_VEC_DEPTH > 1) begin
          rd_en   = 1'b1;
          rd_addr = ADDR_WIDTH'(1);
        end else begin
          rd_en   = 1'b0;
          rd_addr = '0;
        end
      end
      ST_STREAM: begin
        if (prefetch_s) begin
          rd_en   = 1'b1;
          rd_addr = ADDR_WIDTH'(word_ext_s + 32'd2);
        end else begin
          rd_en   = 1'b0;
          rd_addr = '0;
        end
      end
      default: begin
        rd_en   = 1'b0;
        rd_addr = '0;
      end
    endcase
  end

  // Control FSM, word/lane bookkeeping, prefetch buffer and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      word_r     <= '0;
      lane_r     <= '0;
      cur_word_r <= '0;
      nxt_word_r <= '0;
      nxt_vld_r  <= 1'b0;
      pend_r     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_index    <= '0;
      m_last     <= 1'b0;
    end else begin
      pend_r <= rd_en;
      done   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_FETCH0;
            busy    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH0: begin
          state_r <= ST_LOAD0;
        end
        ST_LOAD0: begin
          cur_word_r <= rd_q;
          word_r     <= '0;
          lane_r     <= '0;
          nxt_vld_r  <= 1'b0;
          m_valid    <= 1'b1;
          m_data     <= rd_q[DATA_WIDTH-1:0];
          m_index    <= '0;
          m_last     <= (LAST_IDX == '0);
          state_r    <= ST_STREAM;
        end
        ST_STREAM: begin
          if (xfer_s && m_last) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_FINISH;
          end else if (xfer_s && (lane_r != final_lane_s)) begin
            lane_r  <= lane_inc_s;
            m_data  <= cur_word_r[lane_inc_s*DATA_WIDTH +: DATA_WIDTH];
            m_index <= idx_inc_s;
            m_last  <= (idx_inc_s == LAST_IDX);
          end else if (need_word_s) begin
            if (have_word_s) begin
              cur_word_r <= src_word_s;
              word_r     <= word_r + ADDR_WIDTH'(1);
              lane_r     <= '0;
              nxt_vld_r  <= 1'b0;
              m_valid    <= 1'b1;
              m_data     <= src_word_s[DATA_WIDTH-1:0];
              m_index    <= idx_inc_s;
              m_last     <= (idx_inc_s == LAST_IDX);
            end else begin
              m_valid <= 1'b0;
            end
          end
          // Returning prefetch data parks in nxt_word unless it was forwarded straight into cur_word.
          if (pend_r && !(switch_s && !nxt_vld_r)) begin
            nxt_word_r <= rd_q;
            nxt_vld_r  <= 1'b1;
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_unpack_reader.sv
// Self-checking bench for vec_unpack_reader.
// Instance A: OUTPUT_DEPTH=40, VEC=16 (3 RAM words, partial last word).
// Instance B: OUTPUT_DEPTH=1, VEC=16 (single word, no prefetch).
// RAM word w lane i holds 100*w+i (instance B adds 7000).

module tb_vec_unpack_reader;

  localparam int DW = 16;
  localparam int NV = 16;
  localparam int DA = 40;
  localparam int VDA = 3;

  logic clk;
  logic rst_n;

  logic            start_a, busy_a, done_a, rd_en_a, m_valid_a, m_ready_a, m_last_a;
  logic [1:0]      rd_addr_a;
  logic [NV*DW-1:0] rd_q_a;
  logic [DW-1:0]   m_data_a;
  logic [5:0]      m_index_a;

  logic            start_b, busy_b, done_b, rd_en_b, m_valid_b, m_ready_b, m_last_b;
  logic [0:0]      rd_addr_b;
  logic [NV*DW-1:0] rd_q_b;
  logic [DW-1:0]   m_data_b;
  logic [0:0]      m_index_b;

  int n_vec = 0;
  int n_err = 0;

  // monitor state for instance A
  int cyc_a = 0, exp_n_a = 0, rd_cnt_a = 0, done_cnt_a = 0, first_valid_a = -1;
  int done_cyc_a = -1, last_cyc_a = -1, busy_cnt_a = 0;
  bit run_on_a = 1'b0;
  logic [DW-1:0] data_log [0:DA-1];

  vec_unpack_reader #(.OUTPUT_DEPTH(DA), .DATA_WIDTH(DW), .VEC(NV)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_q(rd_q_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a),
    .m_index(m_index_a), .m_last(m_last_a));

  vec_unpack_reader #(.OUTPUT_DEPTH(1), .DATA_WIDTH(DW), .VEC(NV)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_q(rd_q_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
    .m_index(m_index_b), .m_last(m_last_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [NV*DW-1:0] ram_word(input int base, input int w);
    logic [NV*DW-1:0] r;
    r = '0;
    for (int i = 0; i < NV; i++) r[i*DW +: DW] = 16'(base + 100*w + i);
    return r;
  endfunction

  // element n of the layer output, straight from the element/word/lane rule
  function automatic int exp_elem(input int n);
    return 100*(n / NV) + (n % NV);
  endfunction

  // synchronous RAM models
  always @(posedge clk) begin
    if (rd_en_a) rd_q_a <= ram_word(0, int'(rd_addr_a));
    if (rd_en_b) rd_q_b <= ram_word(7000, int'(rd_addr_b));
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // per-cycle compare process for instance A, sampling on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run_on_a = 1'b0;
      end else begin
        if (start_a && !busy_a) begin
          cyc_a = 0; exp_n_a = 0; rd_cnt_a = 0; done_cnt_a = 0; first_valid_a = -1;
          done_cyc_a = -1; last_cyc_a = -1; busy_cnt_a = 0; run_on_a = 1'b1;
        end else begin
          cyc_a++;
        end
        if (run_on_a) begin
          if (busy_a) busy_cnt_a++;
          if (rd_en_a) begin
            check("rd_addr_order", int'(rd_addr_a), rd_cnt_a);
            rd_cnt_a++;
          end
          if (m_valid_a) begin
            if (first_valid_a < 0) first_valid_a = cyc_a;
            check("m_index", int'(m_index_a), exp_n_a);
            check("m_data", int'(m_data_a), exp_elem(exp_n_a));
            check("m_last", int'(m_last_a), (exp_n_a == DA-1) ? 1 : 0);
            if (m_ready_a) begin
              if (exp_n_a < DA) data_log[exp_n_a] = m_data_a;
              if (m_last_a) last_cyc_a = cyc_a;
              exp_n_a++;
            end
          end
          if (done_a) begin
            done_cnt_a++;
            done_cyc_a = cyc_a;
          end
        end
      end
    end
  end

  // one full run on instance A; mode 0 ready=1, 1 toggle, 2 random,
  // 3 hold ready low ~20 cycles after first valid, 4 ready=1 plus a stray start mid-stream
  task automatic run_a(input int mode);
    bit stall_checked = 1'b0;
    bit stray_sent = 1'b0;
    start_a = 1'b1;
    m_ready_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 400 && done_cnt_a == 0; k++) begin
      case (mode)
        1: m_ready_a = (k % 2 == 0);
        2: m_ready_a = 1'($urandom_range(0, 1));
        3: begin
          if (first_valid_a >= 0 && cyc_a >= first_valid_a + 19) begin
            if (!stall_checked) begin
              check("stall_reads", rd_cnt_a, 2);
              stall_checked = 1'b1;
            end
            m_ready_a = 1'b1;
          end else begin
            m_ready_a = 1'b0;
          end
        end
        default: m_ready_a = 1'b1;
      endcase
      if (mode == 4 && !stray_sent && exp_n_a == 5) begin
        start_a = 1'b1;
        stray_sent = 1'b1;
      end else begin
        start_a = 1'b0;
      end
      tick();
    end
    start_a = 1'b0;
    m_ready_a = 1'b1;
    repeat (4) tick();
    check("done_count", done_cnt_a, 1);
    check("elements", exp_n_a, DA);
    check("read_count", rd_cnt_a, VDA);
    check("done_after_last", done_cyc_a, last_cyc_a + 1);
    check("idle_after", int'({busy_a, m_valid_a, rd_en_a}), 0);
    if (mode == 0) begin
      check("first_valid_cyc", first_valid_a, 3);
      check("done_cyc", done_cyc_a, 43);
      check("busy_cycles", busy_cnt_a, 42);
      check("pin_e0", int'(data_log[0]), 0);
      check("pin_e15", int'(data_log[15]), 15);
      check("pin_e16", int'(data_log[16]), 100);
      check("pin_e39", int'(data_log[39]), 207);
    end
  endtask

  task automatic run_b();
    int rd_n = 0, xf_n = 0, xf_cyc = -1, dn_cyc = -1, fv_cyc = -1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 1; k < 20; k++) begin
      if (rd_en_b) begin
        check("b_rd_addr", int'(rd_addr_b), 0);
        rd_n++;
      end
      if (m_valid_b) begin
        if (fv_cyc < 0) fv_cyc = k;
        check("b_index", int'(m_index_b), 0);
        check("b_last", int'(m_last_b), 1);
        check("b_data", int'(m_data_b), 7000);
        if (m_ready_b) begin
          xf_n++;
          xf_cyc = k;
        end
      end
      if (done_b) dn_cyc = k;
      tick();
    end
    check("b_reads", rd_n, 1);
    check("b_transfers", xf_n, 1);
    check("b_first_valid", fv_cyc, 3);
    check("b_done_cyc", dn_cyc, xf_cyc + 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    m_ready_a = 1'b1;
    m_ready_b = 1'b1;
    repeat (3) tick();
    check("rst_flags_a", int'({busy_a, done_a, rd_en_a, m_valid_a, m_last_a}), 0);
    check("rst_data_a", int'(m_data_a), 0);
    check("rst_idx_addr_a", int'({m_index_a, rd_addr_a}), 0);
    check("rst_flags_b", int'({busy_b, done_b, rd_en_b, m_valid_b, m_last_b}), 0);
    check("model_e16", exp_elem(16), 100);
    check("model_e39", exp_elem(39), 207);
    rst_n = 1'b1;
    repeat (2) tick();

    run_a(0);
    run_a(1);
    run_a(2);
    run_a(3);
    run_a(4);

    // abort mid-stream with reset at element 20
    start_a = 1'b1;
    m_ready_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 200 && exp_n_a < 20; k++) tick();
    check("reach_elem20", exp_n_a, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_flags", int'({busy_a, done_a, rd_en_a, m_valid_a, m_last_a}), 0);
    check("abort_data", int'(m_data_a), 0);
    check("abort_idx_addr", int'({m_index_a, rd_addr_a}), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("post_abort_quiet", int'({busy_a, done_a, rd_en_a, m_valid_a}), 0);
    end

    run_a(0);
    run_b();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
